// File: rtl/spi_reg_ctrl.sv
// Command sequencer behind the SPI byte engine: decodes the frame command byte and
// streams bytes into/out of a small register file with address auto-increment.
module spi_reg_ctrl #(
    parameter int unsigned NREGS     = 16,
    parameter int unsigned DISP_ADDR = 0,
    parameter logic [7:0]  OOR_DATA  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       tx_req,
    output logic [7:0] tx_byte,
    output logic [7:0] disp_num,
    output logic       busy,
    output logic       err
);

    localparam int unsigned AW      = $clog2(NREGS);
    localparam logic [7:0]  NREGS_W = 8'(NREGS);
    localparam logic [6:0]  LAST    = 7'(NREGS - 1);
    localparam logic [6:0]  DISP_A  = 7'(DISP_ADDR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [6:0]  addr, addr_d;
    logic [7:0]  tx_d;
    logic        wr_en, err_set, err_clr;
    logic        cs_n_q;
    logic [7:0]  regs [NREGS];

    function automatic logic in_range(input logic [6:0] a);
        return {1'b0, a} < NREGS_W;
    endfunction

    // In-range addresses wrap at NREGS; out-of-range ones run on to 127 and wrap to 0.
    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        if (in_range(a) && a == LAST)
            return '0;
        return a + 7'd1;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [6:0] a);
        if (in_range(a))
            return regs[a[AW-1:0]];
        return OOR_DATA;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        addr_d     = addr;
        tx_d       = 8'h00;
        wr_en      = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        if (cs_n) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // cs_n_q gates entry so a reset inside a frame waits for a fresh falling edge
                    if (cs_n_q) begin
                        state_next = CMD;
                        err_clr    = 1'b1;
                    end
                end
                CMD: begin
                    if (rx_valid) begin
                        addr_d = rx_byte[6:0];
                        if (rx_byte[7]) begin
                            state_next = READ;
                            tx_d       = rd_byte(rx_byte[6:0]);
                            err_set    = !in_range(rx_byte[6:0]);
                        end else begin
                            state_next = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (rx_valid) begin
                        wr_en   = in_range(addr);
                        err_set = !in_range(addr);
                        addr_d  = addr_inc(addr);
                    end
                end
                READ: begin
                    tx_d = tx_byte;
                    if (tx_req) begin
                        addr_d  = addr_inc(addr);
                        tx_d    = rd_byte(addr_inc(addr));
                        err_set = !in_range(addr_inc(addr));
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            tx_byte  <= '0;
            disp_num <= '0;
            err      <= 1'b0;
            cs_n_q   <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            cs_n_q  <= cs_n;
            addr    <= addr_d;
            tx_byte <= tx_d;
            if (err_clr)
                err <= 1'b0;
            else if (err_set)
                err <= 1'b1;
            if (wr_en) begin
                regs[addr[AW-1:0]] <= rx_byte;
                if (addr == DISP_A)
                    disp_num <= rx_byte;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: stimulus queues expected output values per cycle,
// a negedge monitor pops and compares them.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_n;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_req;
    logic [7:0] tx_byte;
    logic [7:0] disp_num;
    logic       busy;
    logic       err;

    localparam int SIG_TX   = 0;
    localparam int SIG_DISP = 1;
    localparam int SIG_BUSY = 2;
    localparam int SIG_ERR  = 3;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    spi_reg_ctrl #(.NREGS(16), .DISP_ADDR(0), .OOR_DATA(8'hFF)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs_n     (cs_n),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .tx_req   (tx_req),
        .tx_byte  (tx_byte),
        .disp_num (disp_num),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: compare every expectation scheduled for this cycle
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks = checks + 1;
            case (e.sig)
                SIG_TX:   act = tx_byte;
                SIG_DISP: act = disp_num;
                SIG_BUSY: act = {7'd0, busy};
                default:  act = {7'd0, err};
            endcase
            if (e.cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL %s: stale expectation for cycle %0d seen at %0d", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                errors = errors + 1;
                $display("FAIL %s: got 0x%02h, expected 0x%02h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int sig, input logic [7:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        tick();
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic pulse_req(input logic with_rx);
        tx_req   = 1'b1;
        rx_valid = with_rx;
        rx_byte  = 8'hC3;
        tick();
        tx_req   = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    initial begin
        rst = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        repeat (10) tick();
        expect_val("reset_disp", SIG_DISP, 8'h00);
        expect_val("reset_tx",   SIG_TX,   8'h00);
        expect_val("reset_busy", SIG_BUSY, 8'h00);
        expect_val("reset_err",  SIG_ERR,  8'h00);

        // Write 0x5A to reg0 (display register)
        frame_start();
        expect_val("frame_busy", SIG_BUSY, 8'h01);
        send(8'h00);
        expect_val("write_cmd_tx", SIG_TX, 8'h00);
        send(8'h5A);
        expect_val("disp_after_write", SIG_DISP, 8'h5A);
        frame_end();
        expect_val("idle_busy", SIG_BUSY, 8'h00);

        // Burst write then burst read with prefetch
        frame_start(); send(8'h03); send(8'h11); send(8'h22); frame_end();
        frame_start();
        send(8'h83);
        expect_val("read_first", SIG_TX, 8'h11);
        pulse_req(1'b0);
        expect_val("read_second", SIG_TX, 8'h22);
        tick();
        expect_val("read_hold", SIG_TX, 8'h22);
        pulse_req(1'b1);
        expect_val("read_third_rx_same", SIG_TX, 8'h00);
        frame_end();
        expect_val("tx_idle_zero", SIG_TX, 8'h00);

        // Wrap at NREGS-1
        frame_start(); send(8'h0F); send(8'hAA); send(8'hBB);
        expect_val("disp_wrap_write", SIG_DISP, 8'hBB);
        frame_end();
        expect_val("wrap_err", SIG_ERR, 8'h00);
        frame_start();
        send(8'h8F);
        expect_val("read_reg15", SIG_TX, 8'hAA);
        pulse_req(1'b0);
        expect_val("read_wrap_reg0", SIG_TX, 8'hBB);
        frame_end();

        // Out-of-range write, sticky err, cleared at next frame start
        frame_start(); send(8'h20); send(8'h77);
        expect_val("oor_write_err", SIG_ERR, 8'h01);
        frame_end();
        expect_val("err_sticky", SIG_ERR, 8'h01);
        expect_val("oor_disp_unchanged", SIG_DISP, 8'hBB);
        frame_start();
        expect_val("err_cleared", SIG_ERR, 8'h00);
        send(8'hFE);
        expect_val("oor_read_126", SIG_TX, 8'hFF);
        expect_val("oor_read_err", SIG_ERR, 8'h01);
        pulse_req(1'b0);
        expect_val("oor_read_127", SIG_TX, 8'hFF);
        pulse_req(1'b0);
        expect_val("oor_wrap_to_0", SIG_TX, 8'hBB);
        frame_end();

        // cs_n rises together with rx_valid in WRITE: byte dropped
        frame_start(); send(8'h07);
        cs_n = 1'b1; rx_valid = 1'b1; rx_byte = 8'h99;
        tick();
        rx_valid = 1'b0; rx_byte = 8'h00;
        expect_val("abort_busy", SIG_BUSY, 8'h00);
        frame_start();
        send(8'h87);
        expect_val("abort_not_written", SIG_TX, 8'h00);
        frame_end();

        // Reset mid-frame with cs_n held low
        frame_start(); send(8'h01);
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); tick();
        expect_val("rst_mid_busy", SIG_BUSY, 8'h00);
        expect_val("rst_mid_disp", SIG_DISP, 8'h00);
        send(8'h80);
        expect_val("rst_hold_idle", SIG_BUSY, 8'h00);
        frame_end();
        frame_start();
        expect_val("rst_new_frame", SIG_BUSY, 8'h01);
        send(8'h80);
        expect_val("rst_regs_cleared", SIG_TX, 8'h00);
        frame_end();

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
